// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (640x480@60 by default): pixel x/y, active-low syncs, blanking qualifier, frame strobe.
// Latency: every output is a flop decoded from next-state counters, so x/y/syncs/display_on/next_frame share one cycle (zero skew).
// Backpressure: none downstream; enable=0 freezes counters and every output register, stretching any strobe across the pause.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output (frames completed, wraps 255->0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       next_frame
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    // Totals must stay at or below 1024 so the 10-bit counters never overflow.
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       display_on_nxt;
    logic       next_frame_nxt;

    // Next raster position: x wraps at end of line and carries into y, which wraps at end of frame.
    always_comb begin
        x_nxt = x + 10'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
        end
    end

    // Decode qualifiers from the next position so they land in the same cycle as x/y.
    always_comb begin
        hsync_nxt      = !((int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END));
        vsync_nxt      = !((int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END));
        display_on_nxt = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
        next_frame_nxt = (x_nxt == H_LAST) && (y_nxt == V_LAST);
    end

    // Raster and output registers; reset forces idle sync levels and blanks (0,0) of the first frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b0;
            next_frame <= 1'b0;
        end else if (enable) begin
            x          <= x_nxt;
            y          <= y_nxt;
            hsync      <= hsync_nxt;
            vsync      <= vsync_nxt;
            display_on <= display_on_nxt;
            next_frame <= next_frame_nxt;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic frame_wrap;

    // The raster leaves the last pixel of the frame on this enabled edge.
    always_comb begin
        frame_wrap = (x == H_LAST) && (y == V_LAST);
    end

    // Free-running frame counter used downstream as an animation phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (enable && frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a tiny-raster instance for frame-level behaviour.
// A position-index model (pixel number within the frame) predicts every output each cycle; directed literals pin it.
// Define VGA_FRAME_CNT_EN to also exercise frame_cnt over 257 small frames.
module tb_vga_timing_gen;

    // Tiny raster: 12 x 7 = 84 cycles per frame.
    localparam int SHA = 8, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
    localparam int S_HT = SHA + SHF + SHS + SHB;
    localparam int S_VT = SVA + SVF + SVS + SVB;
    localparam int S_TOT = S_HT * S_VT;
    localparam int D_TOT = 800 * 525;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       nf;
    } vout_t;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    logic [9:0] x_d, y_d, x_s, y_s;
    logic hs_d, vs_d, de_d, nf_d;
    logic hs_s, vs_s, de_s, nf_s;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_d, fc_s;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model state: pixel index within the frame, a just-reset flag, and completed-frame counts.
    int p_d = 0;
    int p_s = 0;
    bit fresh = 1'b1;
    int fr_d = 0;
    int fr_s = 0;

    vout_t e_v, g_v;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d),
        .display_on(de_d), .next_frame(nf_d)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
        .display_on(de_s), .next_frame(nf_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    // Outputs implied by pixel index p on a raster with the given timing.
    function automatic vout_t model_out(input int p, input bit fr,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb);
        vout_t o;
        int ht, vt, xx, yy;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        xx = p % ht;
        yy = p / ht;
        o = '0;
        if (fr) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
        end else begin
            o.x  = 10'(xx);
            o.y  = 10'(yy);
            o.hs = !(xx >= ha + hf && xx < ha + hf + hs);
            o.vs = !(yy >= va + vf && yy < va + vf + vs);
            o.de = (xx < ha) && (yy < va);
            o.nf = (xx == ht - 1) && (yy == vt - 1);
        end
        return o;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_out(input string nm, input vout_t g, input vout_t e);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b de=%b nf=%b, expected x=%0d y=%0d hs=%b vs=%b de=%b nf=%b (t=%0t)",
                     nm, g.x, g.y, g.hs, g.vs, g.de, g.nf, e.x, e.y, e.hs, e.vs, e.de, e.nf, $time);
        end
    endtask

    // Advance to just after the next rising edge, where outputs have settled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model advances one pixel per enabled edge; reset returns it to the blanked origin.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_d = 0;
            p_s = 0;
            fresh = 1'b1;
            fr_d = 0;
            fr_s = 0;
        end else if (enable) begin
            fresh = 1'b0;
            p_d = (p_d + 1) % D_TOT;
            p_s = (p_s + 1) % S_TOT;
            if (p_d == 0) fr_d = (fr_d + 1) % 256;
            if (p_s == 0) fr_s = (fr_s + 1) % 256;
        end
    end

    // Every cycle, compare both instances against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            e_v = model_out(p_d, fresh, 640, 16, 96, 48, 480, 10, 2, 33);
            g_v = {x_d, y_d, hs_d, vs_d, de_d, nf_d};
            cmp_out("model_dflt", g_v, e_v);
            e_v = model_out(p_s, fresh, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
            g_v = {x_s, y_s, hs_s, vs_s, de_s, nf_s};
            cmp_out("model_small", g_v, e_v);
`ifdef VGA_FRAME_CNT_EN
            check("model_fcnt_dflt", int'(fc_d), fr_d);
            check("model_fcnt_small", int'(fc_s), fr_s);
`endif
        end
    end

    int hs_low, hs_first, hs_last, de640;
    int nf_cnt, nf_last, nf_gap, vs_low, de_hi, held;

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;

        // Reset held for 5 cycles
        repeat (5) step();
        check("rst_x", int'(x_d), 0);
        check("rst_y", int'(y_d), 0);
        check("rst_hsync", int'(hs_d), 1);
        check("rst_vsync", int'(vs_d), 1);
        check("rst_display_on", int'(de_d), 0);
        check("rst_next_frame", int'(nf_d), 0);

        // First enabled edge
        enable = 1'b1;
        rst_n  = 1'b1;
        step();
        check("first_x", int'(x_d), 1);
        check("first_y", int'(y_d), 0);
        check("first_de", int'(de_d), 1);

        // Rest of the first line
        hs_low = 0; hs_first = -1; hs_last = -1; de640 = -1;
        for (int i = 2; i <= 800; i++) begin
            step();
            if (!hs_d) begin
                if (hs_first < 0) hs_first = int'(x_d);
                hs_last = int'(x_d);
                hs_low++;
            end
            if (x_d == 10'd640) de640 = int'(de_d);
        end
        check("line_wrap_x", int'(x_d), 0);
        check("line_wrap_y", int'(y_d), 1);
        check("hsync_low_cycles", hs_low, 96);
        check("hsync_first_x", hs_first, 656);
        check("hsync_last_x", hs_last, 751);
        check("de_at_x640", de640, 0);

        // Asynchronous reset mid-line at x=300
        repeat (300) step();
        check("pre_arst_x", int'(x_d), 300);
        #1 rst_n = 1'b0;
        #1;
        check("arst_x", int'(x_d), 0);
        check("arst_y", int'(y_d), 0);
        check("arst_hsync", int'(hs_d), 1);
        check("arst_vsync", int'(vs_d), 1);
        check("arst_de", int'(de_d), 0);
        check("arst_nf", int'(nf_d), 0);
        step();
        step();
        rst_n = 1'b1;

        // Pause at x=655, then resume into the hsync pulse
        repeat (655) step();
        check("pause_pre_x", int'(x_d), 655);
        enable = 1'b0;
        repeat (50) step();
        check("pause_x", int'(x_d), 655);
        check("pause_hsync", int'(hs_d), 1);
        check("pause_de", int'(de_d), 0);
        enable = 1'b1;
        step();
        check("resume_x", int'(x_d), 656);
        check("resume_hsync", int'(hs_d), 0);

        // Two tiny frames: strobe count, spacing, position, vsync and active-area totals
        nf_cnt = 0; nf_last = -1; nf_gap = -1; vs_low = 0; de_hi = 0;
        for (int i = 0; i < 2 * S_TOT; i++) begin
            step();
            if (nf_s) begin
                nf_cnt++;
                check("nf_pos_x", int'(x_s), S_HT - 1);
                check("nf_pos_y", int'(y_s), S_VT - 1);
                if (nf_last >= 0) nf_gap = i - nf_last;
                nf_last = i;
            end
            if (!vs_s) vs_low++;
            if (de_s) de_hi++;
        end
        check("nf_pulses", nf_cnt, 2);
        check("nf_gap", nf_gap, 84);
        check("vsync_low_cycles", vs_low, 24);
        check("de_high_cycles", de_hi, 64);

        // Pause on the strobe cycle: it must stay high throughout
        for (int i = 0; i < S_TOT && !nf_s; i++) step();
        check("nf_found", int'(nf_s), 1);
        enable = 1'b0;
        held = 0;
        repeat (20) begin
            step();
            if (nf_s) held++;
        end
        check("nf_held", held, 20);
        enable = 1'b1;
        step();
        check("nf_after_x", int'(x_s), 0);
        check("nf_after_y", int'(y_s), 0);
        check("nf_after_nf", int'(nf_s), 0);

`ifdef VGA_FRAME_CNT_EN
        // 257 tiny frames from a fresh reset: 1, 255, 0, 1
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("fc_rst", int'(fc_s), 0);
        repeat (S_TOT) step();
        check("fc_1", int'(fc_s), 1);
        repeat (254 * S_TOT) step();
        check("fc_255", int'(fc_s), 255);
        repeat (S_TOT) step();
        check("fc_0", int'(fc_s), 0);
        repeat (S_TOT) step();
        check("fc_1_again", int'(fc_s), 1);
`endif

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
